instr_seq: RTL and testbench
============================

INSTR_SEQ -- requirements
Module: instr_seq

Interface
REQ-001 SHALL have parameter AddrSize, default 6, register address width.
REQ-002 SHALL have parameter DataSize, default 32, data and instruction width.
REQ-003 SHALL have parameter ALUopSize, default 4, ALU opcode width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports in_valid input 1, in_ready output 1, in_instr input DataSize: instruction handshake.
REQ-007 SHALL have outputs reg_enable 1, reg_write 1, src1_addr/src2_addr/write_addr AddrSize, write_sel 1, write_data DataSize, alu_enable 1, alu_op ALUopSize; these drive the regfile/ALU subsystem directly.
REQ-008 SHALL have port alu_overflow  input  1  overflow returned by the subsystem.
REQ-009 SHALL have outputs ovf_sticky 1, illegal 1, done 1, retired 16; and input clr_status 1.

Function
REQ-010 SHALL decode in_instr[31:30]: 00 NOP, 01 ALU, 10 LOADI, 11 illegal.
REQ-011 SHALL use ALU fields: [29:26] alu_op, [25:20] rd, [19:14] rs1, [13:8] rs2; [7:0] ignored.
REQ-012 SHALL use LOADI fields: [25:20] rd, [19:0] immediate, zero-extended to DataSize.
REQ-013 SHALL implement FSM states IDLE, READ, EXEC, WB.
REQ-014 SHALL assert in_ready only in IDLE; an instruction is accepted on posedge with in_valid and in_ready both high, and its fields are latched.
REQ-015 SHALL transition on accept: ALU -> READ; LOADI -> WB; NOP and illegal -> stay IDLE.
REQ-016 SHALL transition READ -> EXEC -> WB -> IDLE unconditionally, one cycle each.
REQ-017 SHALL drive in READ: reg_enable=1, reg_write=0, src1_addr=rs1, src2_addr=rs2, alu_enable=0.
REQ-018 SHALL drive in EXEC: reg_enable=0, alu_enable=1, alu_op latched, src addresses held, write_sel=1.
REQ-019 SHALL drive in WB: reg_enable=1, reg_write=1, write_addr=rd, alu_enable=0; for ALU write_sel=1 and alu_enable stays 0; for LOADI write_sel=0 and write_data=immediate.
REQ-020 SHALL drive in IDLE: reg_enable=0, reg_write=0, alu_enable=0; address, alu_op and write_data outputs hold their last values.
REQ-021 SHALL sample alu_overflow at the EXEC posedge; if high, set ovf_sticky.
REQ-022 SHALL set illegal on accept of type 11 (sticky).
REQ-023 SHALL clear ovf_sticky and illegal on clr_status; a set event in the same cycle wins over clr_status.
REQ-024 SHALL pulse done for one cycle on the WB->IDLE transition and on accept of NOP or illegal.
REQ-025 SHALL increment retired at each done pulse, wrapping 0xFFFF -> 0x0000.
REQ-026 SHALL give ALU throughput of one instruction per 4 cycles, LOADI one per 2, NOP one per cycle.
REQ-027 SHALL ignore in_valid outside IDLE; in_instr need not remain stable after accept.

Reset
REQ-028 SHALL on rst enter IDLE and zero all outputs except in_ready, which is 1; rst overrides any state, including mid-instruction, and the aborted instruction produces no write and no done.
REQ-029 SHALL ignore clr_status and alu_overflow while rst is high.

Structure
REQ-030 SHALL place the instruction type codes, field bit positions and FSM state encodings in a shared package alongside AddrSize/DataSize/ALUopSize.
REQ-031 SHALL be a single module with no sub-modules; the decode is inline combinational logic feeding the latched fields.

Verification
REQ-032 SHALL cover: reset; in_valid=1 with ALU op 0, rd=3, rs1=1, rs2=2 -> READ with src 1/2, EXEC with alu_enable, WB with write_addr=3 and write_sel=1, done at cycle 4, retired=1.
REQ-033 SHALL cover: LOADI rd=5, imm=0x12345 -> WB in cycle 2 with write_sel=0, write_data=0x00012345, reg_write=1.
REQ-034 SHALL cover: ALU instruction with alu_overflow=1 in EXEC -> ovf_sticky=1 next cycle; then clr_status -> 0.
REQ-035 SHALL cover: type 11 instruction -> illegal=1, done pulse, no reg_write; then back-to-back NOPs -> one done per cycle.
REQ-036 SHALL cover: rst asserted in EXEC -> next cycle IDLE, in_ready=1, no reg_write, retired unchanged.
REQ-037 SHALL cover: retired preset by 65535 completions -> the next completion wraps it to 0.

Source files
------------

// File: rtl/instr_seq_pkg.sv
// Shared definitions for the instruction sequencer: default widths,
// instruction type codes, instruction field positions and FSM states.
package instr_seq_pkg;

    localparam int ADDR_SIZE    = 6;
    localparam int DATA_SIZE    = 32;
    localparam int ALUOP_SIZE   = 4;
    localparam int RETIRED_SIZE = 16;

    // Instruction type, taken from the top two instruction bits
    typedef enum logic [1:0] {
        ITYPE_NOP     = 2'b00,
        ITYPE_ALU     = 2'b01,
        ITYPE_LOADI   = 2'b10,
        ITYPE_ILLEGAL = 2'b11
    } itype_e;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_e;

    // Instruction field bit positions
    localparam int TYPE_HI = 31;
    localparam int TYPE_LO = 30;
    localparam int OP_HI   = 29;
    localparam int OP_LO   = 26;
    localparam int RD_HI   = 25;
    localparam int RD_LO   = 20;
    localparam int RS1_HI  = 19;
    localparam int RS1_LO  = 14;
    localparam int RS2_HI  = 13;
    localparam int RS2_LO  = 8;
    localparam int IMM_HI  = 19;
    localparam int IMM_LO  = 0;
    localparam int PAD_HI  = 7;

endpackage

// File: rtl/instr_seq.sv
// Instruction sequencer: accepts one instruction at a time and walks the
// register file / ALU subsystem through read, execute and write-back.
module instr_seq
    import instr_seq_pkg::*;
#(
    parameter int AddrSize  = ADDR_SIZE,
    parameter int DataSize  = DATA_SIZE,
    parameter int ALUopSize = ALUOP_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DataSize-1:0]  in_instr,
    output logic                 reg_enable,
    output logic                 reg_write,
    output logic [AddrSize-1:0]  src1_addr,
    output logic [AddrSize-1:0]  src2_addr,
    output logic [AddrSize-1:0]  write_addr,
    output logic                 write_sel,
    output logic [DataSize-1:0]  write_data,
    output logic                 alu_enable,
    output logic [ALUopSize-1:0] alu_op,
    input  logic                 alu_overflow,
    output logic                 ovf_sticky,
    output logic                 illegal,
    output logic                 done,
    output logic [15:0]          retired,
    input  logic                 clr_status
);

    state_e                r_state;
    state_e                w_state_next;
    logic                  w_in_ready;
    logic                  w_reg_enable;
    logic                  w_reg_write;
    logic                  w_alu_enable;
    logic                  w_accept;
    logic                  w_done_next;
    itype_e                w_type;
    logic [AddrSize-1:0]   w_rd;
    logic [AddrSize-1:0]   w_rs1;
    logic [AddrSize-1:0]   w_rs2;
    logic [ALUopSize-1:0]  w_op;
    logic [DataSize-1:0]   w_imm;
    logic                  w_unused;

    logic [AddrSize-1:0]     r_src1;
    logic [AddrSize-1:0]     r_src2;
    logic [AddrSize-1:0]     r_waddr;
    logic [ALUopSize-1:0]    r_op;
    logic [DataSize-1:0]     r_wdata;
    logic                    r_wsel;
    logic                    r_done;
    logic [RETIRED_SIZE-1:0] r_retired;
    logic                    r_ovf;
    logic                    r_illegal;

    // Inline decode of the incoming instruction word
    assign w_type   = itype_e'(in_instr[TYPE_HI:TYPE_LO]);
    assign w_op     = ALUopSize'(in_instr[OP_HI:OP_LO]);
    assign w_rd     = AddrSize'(in_instr[RD_HI:RD_LO]);
    assign w_rs1    = AddrSize'(in_instr[RS1_HI:RS1_LO]);
    assign w_rs2    = AddrSize'(in_instr[RS2_HI:RS2_LO]);
    assign w_imm    = DataSize'(in_instr[IMM_HI:IMM_LO]);
    assign w_unused = ^in_instr[PAD_HI:0];

    // in_valid is only looked at while idle; elsewhere it is ignored
    assign w_accept = in_valid && (r_state == ST_IDLE);

    // Completion: leaving write-back, or a NOP/illegal that retires on accept
    assign w_done_next = (r_state == ST_WB) ||
                         (w_accept && ((w_type == ITYPE_NOP) || (w_type == ITYPE_ILLEGAL)));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and per-state strobes
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_reg_enable = 1'b0;
        w_reg_write  = 1'b0;
        w_alu_enable = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    case (w_type)
                        ITYPE_ALU:   w_state_next = ST_READ;
                        ITYPE_LOADI: w_state_next = ST_WB;
                        default:     w_state_next = ST_IDLE;
                    endcase
                end
            end
            ST_READ: begin
                w_reg_enable = 1'b1;
                w_state_next = ST_EXEC;
            end
            ST_EXEC: begin
                w_alu_enable = 1'b1;
                w_state_next = ST_WB;
            end
            ST_WB: begin
                w_reg_enable = 1'b1;
                w_reg_write  = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Latch instruction fields on accept; they hold until the next ALU/LOADI
    always_ff @(posedge clk) begin
        if (rst) begin
            r_src1  <= '0;
            r_src2  <= '0;
            r_waddr <= '0;
            r_op    <= '0;
            r_wdata <= '0;
            r_wsel  <= 1'b0;
        end else if (w_accept) begin
            if (w_type == ITYPE_ALU) begin
                r_src1  <= w_rs1;
                r_src2  <= w_rs2;
                r_waddr <= w_rd;
                r_op    <= w_op;
                r_wsel  <= 1'b1;
            end else if (w_type == ITYPE_LOADI) begin
                r_waddr <= w_rd;
                r_wdata <= w_imm;
                r_wsel  <= 1'b0;
            end
        end
    end

    // Completion pulse and retired counter (wraps naturally at 16 bits)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done    <= 1'b0;
            r_retired <= '0;
        end else begin
            r_done <= w_done_next;
            if (w_done_next) begin
                r_retired <= r_retired + 16'd1;
            end
        end
    end

    // Sticky status flags; a set event beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf     <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            if ((r_state == ST_EXEC) && alu_overflow) begin
                r_ovf <= 1'b1;
            end else if (clr_status) begin
                r_ovf <= 1'b0;
            end
            if (w_accept && (w_type == ITYPE_ILLEGAL)) begin
                r_illegal <= 1'b1;
            end else if (clr_status) begin
                r_illegal <= 1'b0;
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign reg_enable = w_reg_enable;
    assign reg_write  = w_reg_write;
    assign alu_enable = w_alu_enable;
    assign src1_addr  = r_src1;
    assign src2_addr  = r_src2;
    assign write_addr = r_waddr;
    assign alu_op     = r_op;
    assign write_data = r_wdata;
    assign write_sel  = r_wsel;
    assign done       = r_done;
    assign retired    = r_retired;
    assign ovf_sticky = r_ovf;
    assign illegal    = r_illegal;

endmodule

// File: tb/tb_instr_seq.sv
// Bench for instr_seq: directed vector table, a counter-wrap sequence and
// a randomized run against a transaction-level reference model.
module tb_instr_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        reg_enable;
    logic        reg_write;
    logic [5:0]  src1_addr;
    logic [5:0]  src2_addr;
    logic [5:0]  write_addr;
    logic        write_sel;
    logic [31:0] write_data;
    logic        alu_enable;
    logic [3:0]  alu_op;
    logic        alu_overflow;
    logic        ovf_sticky;
    logic        illegal;
    logic        done;
    logic [15:0] retired;
    logic        clr_status;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    instr_seq dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .reg_enable   (reg_enable),
        .reg_write    (reg_write),
        .src1_addr    (src1_addr),
        .src2_addr    (src2_addr),
        .write_addr   (write_addr),
        .write_sel    (write_sel),
        .write_data   (write_data),
        .alu_enable   (alu_enable),
        .alu_op       (alu_op),
        .alu_overflow (alu_overflow),
        .ovf_sticky   (ovf_sticky),
        .illegal      (illegal),
        .done         (done),
        .retired      (retired),
        .clr_status   (clr_status)
    );

    typedef struct {
        bit          rdy, ren, rw, ae, done, wsel, ovfs, ill;
        logic [5:0]  src1, src2, wa;
        logic [3:0]  op;
        logic [31:0] wdata;
        logic [15:0] ret;
    } exp_t;

    typedef struct {
        bit          rst, valid, ovf, clr;
        logic [31:0] instr;
        exp_t        e;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] enc_alu(int op, int rd, int rs1, int rs2);
        return {2'b01, op[3:0], rd[5:0], rs1[5:0], rs2[5:0], 8'h5A};
    endfunction

    function automatic logic [31:0] enc_loadi(int rd, int imm);
        return {2'b10, 4'hF, rd[5:0], imm[19:0]};
    endfunction

    function automatic exp_t ex(bit rdy, bit ren, bit rw, bit ae, bit dn,
                                int s1, int s2, int op, int wa, bit wsel, int wd,
                                bit ovfs, bit ill, int ret);
        exp_t e;
        e.rdy = rdy; e.ren = ren; e.rw = rw; e.ae = ae; e.done = dn;
        e.src1 = s1[5:0]; e.src2 = s2[5:0]; e.op = op[3:0]; e.wa = wa[5:0];
        e.wsel = wsel; e.wdata = wd; e.ovfs = ovfs; e.ill = ill; e.ret = ret[15:0];
        return e;
    endfunction

    task automatic add(bit r, bit v, logic [31:0] ins, bit o, bit c, exp_t e);
        vec_t x;
        x.rst = r; x.valid = v; x.instr = ins; x.ovf = o; x.clr = c; x.e = e;
        vecs.push_back(x);
    endtask

    task automatic chk(input string tag, input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s %s: got 0x%0h expected 0x%0h", tag, nm, act, expv);
        end
    endtask

    // Compare all outputs; fields the behaviour leaves open in a phase are skipped
    task automatic cmp_all(input string tag, input exp_t e);
        bit idle, st_r, st_e, st_w;
        idle = e.rdy;
        st_r = e.ren && !e.rw;
        st_e = e.ae;
        st_w = e.rw;
        chk(tag, "in_ready",   in_ready,   e.rdy);
        chk(tag, "reg_enable", reg_enable, e.ren);
        chk(tag, "reg_write",  reg_write,  e.rw);
        chk(tag, "alu_enable", alu_enable, e.ae);
        chk(tag, "done",       done,       e.done);
        chk(tag, "ovf_sticky", ovf_sticky, e.ovfs);
        chk(tag, "illegal",    illegal,    e.ill);
        chk(tag, "retired",    retired,    e.ret);
        if (idle || st_r || st_e) begin
            chk(tag, "src1_addr", src1_addr, e.src1);
            chk(tag, "src2_addr", src2_addr, e.src2);
        end
        if (idle || st_e) chk(tag, "alu_op", alu_op, e.op);
        if (idle || st_w) chk(tag, "write_addr", write_addr, e.wa);
        if (idle || (st_w && !e.wsel)) chk(tag, "write_data", write_data, e.wdata);
        if (st_e || st_w) chk(tag, "write_sel", write_sel, e.wsel);
    endtask

    task automatic drive(bit r, bit v, logic [31:0] ins, bit o, bit c);
        rst = r; in_valid = v; in_instr = ins; alu_overflow = o; clr_status = c;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference model state for the randomized run
    byte         stg_q[$];
    byte         cur;
    bit          m_done, m_ovf, m_ill, m_wsel;
    int          m_ret;
    logic [5:0]  m_src1, m_src2, m_wa;
    logic [3:0]  m_op;
    logic [31:0] m_wdata;

    initial begin
        logic [31:0] a2, a0, ld, aa, a1, illi, nopi;
        logic [31:0] r_ins;
        logic [1:0]  ty;
        bit          r_rst, r_v, r_o, r_c, dn, n_ovf, n_ill;
        exp_t        e;
        int          n_txn;

        a2   = enc_alu(2, 9, 5, 6);
        a0   = enc_alu(0, 3, 1, 2);
        ld   = enc_loadi(5, 'h12345);
        aa   = enc_alu(10, 7, 4, 9);
        a1   = enc_alu(1, 1, 2, 3);
        illi = 32'hFFFF_FFFF;
        nopi = 32'h3FFF_FFFF;

        // rst, valid, instr, ovf, clr | rdy ren rw ae done s1 s2 op wa wsel wdata ovfs ill ret
        add(1,0,nopi,0,0, ex(1,0,0,0,0, 0,0,0,0,0,0,       0,0,0));
        add(0,1,a2,  0,0, ex(0,1,0,0,0, 5,6,0,0,0,0,       0,0,0));
        add(0,0,nopi,0,0, ex(0,0,0,1,0, 5,6,2,0,1,0,       0,0,0));
        add(1,1,a2,  1,1, ex(1,0,0,0,0, 0,0,0,0,0,0,       0,0,0));
        add(0,0,nopi,1,0, ex(1,0,0,0,0, 0,0,0,0,0,0,       0,0,0));
        add(0,1,a0,  0,0, ex(0,1,0,0,0, 1,2,0,0,0,0,       0,0,0));
        add(0,0,nopi,0,0, ex(0,0,0,1,0, 1,2,0,0,1,0,       0,0,0));
        add(0,0,nopi,0,0, ex(0,1,1,0,0, 1,2,0,3,1,0,       0,0,0));
        add(0,0,nopi,0,0, ex(1,0,0,0,1, 1,2,0,3,0,0,       0,0,1));
        add(0,1,ld,  0,0, ex(0,1,1,0,0, 0,0,0,5,0,'h12345, 0,0,1));
        add(0,0,nopi,0,0, ex(1,0,0,0,1, 1,2,0,5,0,'h12345, 0,0,2));
        add(0,1,aa,  0,0, ex(0,1,0,0,0, 4,9,0,0,0,0,       0,0,2));
        add(0,0,nopi,0,0, ex(0,0,0,1,0, 4,9,10,0,1,0,      0,0,2));
        add(0,0,nopi,1,0, ex(0,1,1,0,0, 0,0,0,7,1,0,       1,0,2));
        add(0,0,nopi,0,1, ex(1,0,0,0,1, 4,9,10,7,0,'h12345,0,0,3));
        add(0,1,a1,  0,0, ex(0,1,0,0,0, 2,3,0,0,0,0,       0,0,3));
        add(0,0,nopi,0,0, ex(0,0,0,1,0, 2,3,1,0,1,0,       0,0,3));
        add(0,0,nopi,1,1, ex(0,1,1,0,0, 0,0,0,1,1,0,       1,0,3));
        add(0,0,nopi,1,1, ex(1,0,0,0,1, 2,3,1,1,0,'h12345, 0,0,4));
        add(0,0,nopi,1,0, ex(1,0,0,0,0, 2,3,1,1,0,'h12345, 0,0,4));
        add(0,1,illi,0,0, ex(1,0,0,0,1, 2,3,1,1,0,'h12345, 0,1,5));
        add(0,1,nopi,0,1, ex(1,0,0,0,1, 2,3,1,1,0,'h12345, 0,0,6));
        add(0,1,nopi,0,0, ex(1,0,0,0,1, 2,3,1,1,0,'h12345, 0,0,7));
        add(0,1,nopi,0,0, ex(1,0,0,0,1, 2,3,1,1,0,'h12345, 0,0,8));
        add(0,0,nopi,0,0, ex(1,0,0,0,0, 2,3,1,1,0,'h12345, 0,0,8));
        add(0,1,illi,0,1, ex(1,0,0,0,1, 2,3,1,1,0,'h12345, 0,1,9));
        add(0,0,nopi,0,1, ex(1,0,0,0,0, 2,3,1,1,0,'h12345, 0,0,9));

        drive(1, 0, 32'h0, 0, 0);
        @(negedge clk);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].valid, vecs[i].instr, vecs[i].ovf, vecs[i].clr);
            @(posedge clk);
            @(negedge clk);
            $display("vec%0d rst=%0d valid=%0d instr=%h ovf=%0d clr=%0d -> ready=%0d ren=%0d rw=%0d ae=%0d done=%0d retired=%0d",
                     i, vecs[i].rst, vecs[i].valid, vecs[i].instr, vecs[i].ovf, vecs[i].clr,
                     in_ready, reg_enable, reg_write, alu_enable, done, retired);
            cmp_all($sformatf("vec%0d", i), vecs[i].e);
        end

        // Counter wrap: 65535 back-to-back NOPs, then one LOADI completion
        drive(1, 0, nopi, 0, 0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1, nopi, 0, 0);
        repeat (65535) @(posedge clk);
        @(negedge clk);
        drive(0, 1, ld, 0, 0);
        chk("wrap", "retired_full", retired, 32'hFFFF);
        chk("wrap", "done_full", done, 1);
        @(posedge clk);
        @(negedge clk);
        drive(0, 0, nopi, 0, 0);
        chk("wrap", "reg_write_wb", reg_write, 1);
        chk("wrap", "retired_wb", retired, 32'hFFFF);
        @(posedge clk);
        @(negedge clk);
        $display("wrap: after LOADI completion retired=%0d done=%0d", retired, done);
        chk("wrap", "retired_wrapped", retired, 0);
        chk("wrap", "done_wrapped", done, 1);

        // Randomized run against the transaction-level model
        drive(1, 0, nopi, 0, 0);
        @(posedge clk);
        @(negedge clk);
        stg_q.delete();
        m_done = 0; m_ovf = 0; m_ill = 0; m_wsel = 0; m_ret = 0;
        m_src1 = 0; m_src2 = 0; m_wa = 0; m_op = 0; m_wdata = 0;
        n_txn = 0;
        for (int c = 0; c < 3000; c++) begin
            cur = (stg_q.size() != 0) ? stg_q[0] : "I";
            e.rdy  = (cur == "I");
            e.ren  = (cur == "R") || (cur == "W");
            e.rw   = (cur == "W");
            e.ae   = (cur == "E");
            e.done = m_done;
            e.wsel = m_wsel;
            e.ovfs = m_ovf;
            e.ill  = m_ill;
            e.src1 = m_src1; e.src2 = m_src2; e.wa = m_wa; e.op = m_op;
            e.wdata = m_wdata;
            e.ret  = m_ret[15:0];
            cmp_all($sformatf("rand%0d", c), e);

            r_rst = ($urandom_range(0, 299) == 0);
            r_v   = ($urandom_range(0, 3) != 0);
            r_ins = $urandom;
            r_o   = $urandom_range(0, 1) != 0;
            r_c   = ($urandom_range(0, 7) == 0);
            drive(r_rst, r_v, r_ins, r_o, r_c);
            @(posedge clk);

            if (r_rst) begin
                stg_q.delete();
                m_done = 0; m_ovf = 0; m_ill = 0; m_wsel = 0; m_ret = 0;
                m_src1 = 0; m_src2 = 0; m_wa = 0; m_op = 0; m_wdata = 0;
            end else begin
                dn    = 0;
                n_ill = 0;
                n_ovf = (cur == "E") && r_o;
                if (cur == "I") begin
                    if (r_v) begin
                        n_txn++;
                        ty = r_ins[31:30];
                        case (ty)
                            2'b01: begin
                                stg_q.push_back("R");
                                stg_q.push_back("E");
                                stg_q.push_back("W");
                                m_op = r_ins[29:26]; m_wa = r_ins[25:20];
                                m_src1 = r_ins[19:14]; m_src2 = r_ins[13:8];
                                m_wsel = 1;
                            end
                            2'b10: begin
                                stg_q.push_back("W");
                                m_wa = r_ins[25:20];
                                m_wdata = {12'h0, r_ins[19:0]};
                                m_wsel = 0;
                            end
                            2'b11: begin
                                dn = 1;
                                n_ill = 1;
                            end
                            default: dn = 1;
                        endcase
                    end
                end else begin
                    void'(stg_q.pop_front());
                    if (cur == "W") dn = 1;
                end
                m_ovf = n_ovf ? 1'b1 : (r_c ? 1'b0 : m_ovf);
                m_ill = n_ill ? 1'b1 : (r_c ? 1'b0 : m_ill);
                m_done = dn;
                if (dn) m_ret = (m_ret + 1) % 65536;
            end
            @(negedge clk);
        end
        $display("random: %0d instructions accepted, model retired=%0d", n_txn, m_ret);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
